// File: rtl/min_os_pkg.sv
// Shared definitions for the virtual-peripheral chunk path: framer state
// encoding, default frame sync byte and chunk-type identifiers.
package min_os_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SEND_SYNC    = 3'd1,
        ST_SEND_TYPE    = 3'd2,
        ST_SEND_PAYLOAD = 3'd3,
        ST_ACK          = 3'd4
    } frame_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

    // Chunk types carried in the TYPE byte of a frame
    localparam logic [7:0] CHUNK_NONE      = 8'd0;
    localparam logic [7:0] CHUNK_BUTTONS   = 8'd1;
    localparam logic [7:0] CHUNK_LEDS      = 8'd2;
    localparam logic [7:0] CHUNK_SEVEN_SEG = 8'd3;
    localparam logic [7:0] CHUNK_SWITCHES  = 8'd4;

    // True in the states that present a byte to the UART
    function automatic logic is_send_state(frame_state_e s);
        return (s == ST_SEND_SYNC) || (s == ST_SEND_TYPE) || (s == ST_SEND_PAYLOAD);
    endfunction

endpackage

// File: rtl/tx_chunk_framer_if.sv
// Byte-level valid/ready link between the chunk framer and the UART
// transmitter. The framer is the master.
interface tx_chunk_framer_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;

    modport master (output uart_tx_data, output uart_tx_valid, input uart_tx_ready);
    modport slave  (input uart_tx_data, input uart_tx_valid, output uart_tx_ready);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational and one-hot; the
// last-grant memory only moves when the caller commits the grant.
module rr_arbiter2 #(
    parameter bit CH0_PRIORITY_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    // 1 means channel 1 was served last, so channel 0 wins the next tie
    logic last_grant;

    // Single requester wins outright; on a tie the channel not served last wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the committed winner for the next contended round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= CH0_PRIORITY_FIRST;
        else if (grant_en && (|grant))
            last_grant <= grant[1];
    end

endmodule

// File: rtl/tx_chunk_framer.sv
// Arbitrates two chunk producers and serializes the winner as a
// SYNC/TYPE/PAYLOAD frame to the UART, then acks that producer for one cycle.
module tx_chunk_framer
    import min_os_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE          = DEFAULT_SYNC_BYTE,
    parameter bit         CH0_PRIORITY_FIRST = 1'b1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ch0_should_update,
    input  logic [7:0]          ch0_tx_chunk_type,
    input  logic [7:0]          ch0_tx_chunk_bytes,
    output logic                ch0_reset,
    input  logic                ch1_should_update,
    input  logic [7:0]          ch1_tx_chunk_type,
    input  logic [7:0]          ch1_tx_chunk_bytes,
    output logic                ch1_reset,
    tx_chunk_framer_if.master   uart,
    output logic                busy
);

    frame_state_e state, state_nxt;
    logic [1:0]   req, grant;
    logic         grant_en;
    logic [7:0]   type_q, payload_q;
    logic         grant_ch;

    assign req = {ch1_should_update, ch0_should_update};

    rr_arbiter2 #(
        .CH0_PRIORITY_FIRST(CH0_PRIORITY_FIRST)
    ) u_arb (
        .clk      (CLK),
        .rst_n    (RST_N),
        .req      (req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: grant only from IDLE, advance bytes on ready, ACK lasts one cycle
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_SEND_SYNC;
                end
            end
            ST_SEND_SYNC:    if (uart.uart_tx_ready) state_nxt = ST_SEND_TYPE;
            ST_SEND_TYPE:    if (uart.uart_tx_ready) state_nxt = ST_SEND_PAYLOAD;
            ST_SEND_PAYLOAD: if (uart.uart_tx_ready) state_nxt = ST_ACK;
            ST_ACK:          state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's chunk at grant so later input changes can't touch the frame
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            type_q    <= 8'h00;
            payload_q <= 8'h00;
            grant_ch  <= 1'b0;
        end else if (grant_en) begin
            type_q    <= grant[1] ? ch1_tx_chunk_type  : ch0_tx_chunk_type;
            payload_q <= grant[1] ? ch1_tx_chunk_bytes : ch0_tx_chunk_bytes;
            grant_ch  <= grant[1];
        end
    end

    // Registered outputs decoded from the state being entered, so they line up
    // with the state register; type/payload are already latched by then
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            uart.uart_tx_valid <= 1'b0;
            uart.uart_tx_data  <= 8'h00;
            ch0_reset          <= 1'b0;
            ch1_reset          <= 1'b0;
            busy               <= 1'b0;
        end else begin
            uart.uart_tx_valid <= is_send_state(state_nxt);
            case (state_nxt)
                ST_SEND_SYNC:    uart.uart_tx_data <= SYNC_BYTE;
                ST_SEND_TYPE:    uart.uart_tx_data <= type_q;
                ST_SEND_PAYLOAD: uart.uart_tx_data <= payload_q;
                default:         uart.uart_tx_data <= 8'h00;
            endcase
            ch0_reset <= (state_nxt == ST_ACK) && !grant_ch;
            ch1_reset <= (state_nxt == ST_ACK) &&  grant_ch;
            busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tx_chunk_framer.sv
// Scoreboard bench for tx_chunk_framer: each requested chunk pushes its three
// expected bytes and its expected ack; the monitor pops them as the DUT emits.
module tb_tx_chunk_framer;
    import min_os_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ch0_req = 1'b0, ch1_req = 1'b0;
    logic [7:0] ch0_type = 8'h00, ch0_pay = 8'h00;
    logic [7:0] ch1_type = 8'h00, ch1_pay = 8'h00;
    logic       ch0_ack, ch1_ack, busy;

    tx_chunk_framer_if uif();

    tx_chunk_framer #(
        .SYNC_BYTE          (8'hAA),
        .CH0_PRIORITY_FIRST (1'b1)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .ch0_should_update  (ch0_req),
        .ch0_tx_chunk_type  (ch0_type),
        .ch0_tx_chunk_bytes (ch0_pay),
        .ch0_reset          (ch0_ack),
        .ch1_should_update  (ch1_req),
        .ch1_tx_chunk_type  (ch1_type),
        .ch1_tx_chunk_bytes (ch1_pay),
        .ch1_reset          (ch1_ack),
        .uart               (uif.master),
        .busy               (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_byte_t;

    exp_byte_t  byte_q[$];
    logic [1:0] ack_q[$];
    exp_byte_t  mon_e;
    logic [1:0] mon_a;
    int         total = 0;
    int         bad = 0;
    int         ch0_left = 0;
    int         ch1_left = 0;
    bit         ack_due = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_word = 9'h0;
    bit         noisy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int ch, input logic [7:0] t, input logic [7:0] p);
        byte_q.push_back('{8'hAA, 1'b0});
        byte_q.push_back('{t, 1'b0});
        byte_q.push_back('{p, 1'b1});
        ack_q.push_back(ch != 0 ? 2'b10 : 2'b01);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (byte_q.size() == 0 && ack_q.size() == 0 && !busy) break;
        end
        chk("drain", byte_q.size() + ack_q.size() + int'(busy), 0);
    endtask

    // Monitor: byte/ack scoreboard, stall-hold and ack-follows-payload checks
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall = 1'b0;
            ack_due    = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {uif.uart_tx_valid, uif.uart_tx_data}, prev_word);
            if (ack_due)
                chk("ack_timing", ch0_ack | ch1_ack, 1);
            ack_due = 1'b0;
            if (uif.uart_tx_valid && uif.uart_tx_ready) begin
                if (byte_q.size() == 0) begin
                    chk("extra_byte", 1, 0);
                end else begin
                    mon_e = byte_q.pop_front();
                    chk("byte", uif.uart_tx_data, mon_e.data);
                    ack_due = mon_e.last;
                end
            end
            if (ch0_ack || ch1_ack) begin
                if (ack_q.size() == 0) begin
                    chk("extra_ack", {ch1_ack, ch0_ack}, 0);
                end else begin
                    mon_a = ack_q.pop_front();
                    chk("ack", {ch1_ack, ch0_ack}, mon_a);
                end
            end
            prev_stall = uif.uart_tx_valid && !uif.uart_tx_ready;
            prev_word  = {uif.uart_tx_valid, uif.uart_tx_data};
        end
    end

    // Producer model: drop the request once the expected number of acks arrived
    always @(negedge CLK) begin
        if (ch0_ack && ch0_left > 0) begin
            ch0_left--;
            if (ch0_left == 0) ch0_req = 1'b0;
        end
        if (ch1_ack && ch1_left > 0) begin
            ch1_left--;
            if (ch1_left == 0) ch1_req = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        uif.uart_tx_ready = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", uif.uart_tx_valid, 0);
        chk("rst_data", uif.uart_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ch1_ack, ch0_ack}, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Single request, ready tied high
        uif.uart_tx_ready = 1'b1;
        ch0_type = CHUNK_LEDS; ch0_pay = 8'h5A; ch0_left = 1;
        push_frame(0, CHUNK_LEDS, 8'h5A);
        ch0_req = 1'b1;
        wait_drain(50);

        // Backpressure for 4 cycles on the TYPE byte
        @(posedge CLK); #1;
        ch0_pay = 8'h3C; ch0_left = 1;
        push_frame(0, CHUNK_LEDS, 8'h3C);
        ch0_req = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        uif.uart_tx_ready = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("bp_word", {busy, uif.uart_tx_valid, uif.uart_tx_data}, {2'b11, 8'h02});
        end
        @(posedge CLK); #1;
        uif.uart_tx_ready = 1'b1;
        wait_drain(50);

        // Contention straight after reset: strict ch0/ch1 alternation
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        ch0_type = CHUNK_LEDS;      ch0_pay = 8'h01;
        ch1_type = CHUNK_SEVEN_SEG; ch1_pay = 8'hF0;
        ch0_left = 2; ch1_left = 2;
        push_frame(0, CHUNK_LEDS, 8'h01);
        push_frame(1, CHUNK_SEVEN_SEG, 8'hF0);
        push_frame(0, CHUNK_LEDS, 8'h01);
        push_frame(1, CHUNK_SEVEN_SEG, 8'hF0);
        ch0_req = 1'b1; ch1_req = 1'b1;
        wait_drain(100);

        // Payload changed after grant must not reach the wire
        @(posedge CLK); #1;
        ch0_type = CHUNK_LEDS; ch0_pay = 8'h11; ch0_left = 1;
        push_frame(0, CHUNK_LEDS, 8'h11);
        ch0_req = 1'b1;
        @(posedge CLK); #1;
        ch0_pay = 8'h22;
        wait_drain(50);

        // Reset while stalled on TYPE: abandon the frame, no ack, then a fresh frame
        @(posedge CLK); #1;
        ch0_pay = 8'h77; ch0_left = 1;
        push_frame(0, CHUNK_LEDS, 8'h77);
        ch0_req = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        uif.uart_tx_ready = 1'b0;
        @(posedge CLK); #2;
        chk("pre_rst_valid", uif.uart_tx_valid, 1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", uif.uart_tx_valid, 0);
        chk("mid_rst_out", {busy, ch1_ack, ch0_ack, uif.uart_tx_data}, 0);
        byte_q.delete();
        ack_q.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        uif.uart_tx_ready = 1'b1;
        push_frame(0, CHUNK_LEDS, 8'h77);
        wait_drain(50);

        // Quiet idle
        noisy = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            noisy |= uif.uart_tx_valid | busy | ch0_ack | ch1_ack;
        end
        chk("idle_quiet", noisy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_chunk_framer.md
Name: tx_chunk_framer

Overview:
- Downstream consumer of the virtual-peripheral chunk producers, such as the LED mirror. Each producer raises a request flag alongside a stable chunk type and a one-byte chunk payload.
- Arbitrates round-robin between two producer channels. Serializes the granted chunk as a 3-byte frame (SYNC, TYPE, PAYLOAD) into the byte-level UART transmitter over a valid/ready handshake.
- After the last byte is accepted, returns a one-cycle acknowledge to the granted producer, which clears that producer's request.

Parameters:
- SYNC_BYTE, 8'hAA, first byte of every frame.
- CH0_PRIORITY_FIRST, 1, when 1 channel 0 wins the first contended arbitration after reset; when 0 channel 1 wins.

Ports:
- CLK  in  1  system clock; all logic is on posedge.
- RST_N  in  1  asynchronous active-low reset.
- ch0_should_update  in  1  channel 0 request, level, held until acked.
- ch0_tx_chunk_type  in  8  channel 0 chunk type.
- ch0_tx_chunk_bytes  in  8  channel 0 payload.
- ch0_reset  out  1  channel 0 acknowledge, one-cycle pulse.
- ch1_should_update  in  1  channel 1 request.
- ch1_tx_chunk_type  in  8  channel 1 chunk type.
- ch1_tx_chunk_bytes  in  8  channel 1 payload.
- ch1_reset  out  1  channel 1 acknowledge pulse.
- uart_tx_data  out  8  byte presented to the UART transmitter.
- uart_tx_valid  out  1  uart_tx_data is valid.
- uart_tx_ready  in  1  UART accepts the byte when valid && ready at a posedge.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; uart_tx_valid=0; uart_tx_data=0.
  - ch0_reset=0; ch1_reset=0; busy=0; latched type/payload=0.
  - last_grant=1 if CH0_PRIORITY_FIRST else 0.
- States: IDLE, SEND_SYNC, SEND_TYPE, SEND_PAYLOAD, ACK.
- IDLE, arbitration:
  - If exactly one request is high, grant that channel.
  - If both are high, grant the channel != last_grant.
  - On grant, at the same edge: latch the granted type and payload, record grant_ch, set last_grant=grant_ch, move to SEND_SYNC.
  - Latency from request seen in IDLE to first valid byte: 1 cycle.
- SEND_SYNC / SEND_TYPE / SEND_PAYLOAD:
  - uart_tx_valid=1, with data = SYNC_BYTE, latched type, and latched payload respectively.
  - Advance to the next state at the edge where uart_tx_ready=1.
  - While ready=0, data and valid are held stable. No timeout; stall indefinitely.
  - Consecutive bytes may be accepted on back-to-back cycles; a frame takes at minimum 3 cycles.
- From SEND_PAYLOAD, acceptance moves to ACK.
- ACK:
  - uart_tx_valid=0. Assert ch<grant_ch>_reset=1 for exactly this one cycle; the other ack stays 0.
  - Next state is IDLE unconditionally.
  - The producer drops its request at the same edge, so IDLE never re-grants a stale request.
- Outputs are registered. ack pulses are decoded from the registered state, never from inputs.
- Input changes after the grant edge do not affect the frame in flight; the latched values are used.
- A request arriving while busy waits; it is served after ACK.
- Contention is strictly alternating: ch0, ch1, ch0, and so on.
- A request withdrawn before grant is ignored. A request withdrawn mid-frame still completes the frame and still emits the ack.
- RST_N asserted mid-frame: outputs return to reset values immediately; the partial frame is abandoned and no ack is issued.

Decomposition:
- Shared package (min_os_pkg) holds:
  - frame state encoding constants.
  - default SYNC_BYTE.
  - chunk-type constants: LEDS=2 and the other peripheral types.
- One natural sub-module: rr_arbiter2 (two requests, last_grant register, one-hot grant output). Its last_grant update is qualified by the framer's grant-enable signal.
- Byte sequencing stays in the top module.

Test Plan:
- Single request: ch0 request with type=2, payload=8'h5A, ready tied 1 -> uart bytes AA, 02, 5A on 3 consecutive cycles. ch0_reset pulses 1 cycle in the next cycle; ch1_reset stays 0.
- Backpressure: ready low for 4 cycles during the TYPE byte -> data holds 02 with valid=1 throughout; frame completes after ready rises; exactly one ack.
- Contention:
  - Stimulus: both request continuously after reset, ch0 type=2/payload=8'h01, ch1 type=3/payload=8'hF0.
  - Response: frames alternate ch0, ch1, ch0, and each ack goes only to its own channel.
- Payload latched at grant: change ch0 payload from 8'h11 to 8'h22 during SEND_SYNC -> transmitted payload is 11.
- Reset mid-frame: pull RST_N low during SEND_TYPE -> valid=0 asynchronously, no ack pulse. After release with ch0 still requesting, a full new frame AA,02,xx follows.
- Idle quiet: no requests for 100 cycles -> valid=0, busy=0, both acks 0 throughout.
